// File: rtl/apb_cmd_master.sv
// APB4 master sequencer: runs one write or read-compare command per SETUP/ACCESS transfer,
// checks read data under a mask and PSLVERR against an expected value, and counts failures.
module apb_cmd_master #(
    parameter  int ADDR_W  = 12,
    parameter  int DATA_W  = 32,
    parameter  int ERR_W   = 16,
    parameter  int TIMEOUT = 16,
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_strb,
    input  logic [DATA_W-1:0] cmd_exp,
    input  logic [DATA_W-1:0] cmd_mask,
    input  logic              cmd_experr,
    input  logic              err_clr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [STRB_W-1:0] pstrb,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fail,
    output logic              rsp_timeout,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                write_q;
    logic                experr_q;
    logic [DATA_W-1:0]   exp_q;
    logic [DATA_W-1:0]   mask_q;

    logic                data_miss;
    logic                status_miss;
    logic                timeout_hit;
    logic                xfer_fail;

    // NOTE: every combinational output is assigned on every path, so no latch can be inferred.
    always_comb begin
        data_miss   = !write_q && (((prdata ^ exp_q) & mask_q) != '0);
        status_miss = (pslverr != experr_q);
        // pready is tested first so a response on the limit cycle beats the timeout
        timeout_hit = (state == ACCESS) && !pready && (wait_cnt == WAIT_LAST);
        xfer_fail   = (state == ACCESS) && (pready ? (data_miss || status_miss) : timeout_hit);
    end

    // NOTE: clocked state uses non-blocking assignments only; reset is asynchronous and active-high.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            wait_cnt    <= '0;
            write_q     <= 1'b0;
            experr_q    <= 1'b0;
            exp_q       <= '0;
            mask_q      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_fail    <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_fail    <= 1'b0;
            rsp_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= SETUP;
                        cmd_ready <= 1'b0;
                        psel      <= 1'b1;
                        pwrite    <= cmd_write;
                        paddr     <= cmd_addr;
                        pwdata    <= cmd_write ? cmd_wdata : '0;
                        pstrb     <= cmd_write ? cmd_strb : '0;
                        wait_cnt  <= '0;
                        write_q   <= cmd_write;
                        experr_q  <= cmd_experr;
                        exp_q     <= cmd_exp;
                        mask_q    <= cmd_mask;
                    end
                end

                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end

                ACCESS: begin
                    if (pready || timeout_hit) begin
                        state       <= IDLE;
                        cmd_ready   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        pwrite      <= 1'b0;
                        paddr       <= '0;
                        pwdata      <= '0;
                        pstrb       <= '0;
                        rsp_valid   <= 1'b1;
                        rsp_fail    <= xfer_fail;
                        rsp_timeout <= !pready;
                        rsp_rdata   <= (pready && !write_q) ? prdata : '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                end
            endcase
        end
    end

    // A clear wins over older history, but a failure finishing on the same edge still counts.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= xfer_fail ? ERR_W'(1) : '0;
        end else if (xfer_fail && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

    a_penable_in_sel : assert property (@(posedge clk) disable iff (rst_n) penable |-> psel);
    a_timeout_flags  : assert property (@(posedge clk) disable iff (rst_n)
                                        rsp_timeout |-> (rsp_valid && rsp_fail));

endmodule

// File: tb/tb_apb_cmd_master.sv
// Randomised scoreboard bench for apb_cmd_master: a driver issues commands and pushes predicted
// responses; a monitor checks APB phases and responses; a simple slave supplies wait states.
module tb_apb_cmd_master;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;
    localparam int ERR_W   = 5;
    localparam int TIMEOUT = 16;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
    localparam int STUCK   = 1000;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;
    logic [DATA_W-1:0] cmd_exp;
    logic [DATA_W-1:0] cmd_mask;
    logic              cmd_experr;
    logic              err_clr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_fail;
    logic              rsp_timeout;
    logic [ERR_W-1:0]  err_cnt;

    apb_cmd_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ERR_W  (ERR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .cmd_exp    (cmd_exp),
        .cmd_mask   (cmd_mask),
        .cmd_experr (cmd_experr),
        .err_clr    (err_clr),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fail   (rsp_fail),
        .rsp_timeout(rsp_timeout),
        .err_cnt    (err_cnt)
    );

    typedef struct {
        bit                write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] exp;
        logic [DATA_W-1:0] mask;
        bit                experr;
        int                waits;
        logic [DATA_W-1:0] rdata;
        bit                slverr;
        bit                clr;
    } txn_t;

    typedef struct {
        int                acc_cyc;
        bit                write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] rdata;
        bit                fail;
        bit                tmo;
        int                err;
        int                acc_cycles;
    } exp_t;

    exp_t              sb[$];
    exp_t              mon_e;
    int                total;
    int                bad;
    int                cyc;
    int                mcnt;
    int                acc_seen;
    int                slv_n;
    int                slv_waits;
    logic [DATA_W-1:0] slv_rdata;
    bit                slv_slverr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    // Slave: holds pready low for slv_waits ACCESS cycles, noise everywhere outside ACCESS.
    always @(negedge clk) begin
        if (psel && penable) begin
            if (slv_n >= slv_waits) begin
                pready  = 1'b1;
                prdata  = slv_rdata;
                pslverr = slv_slverr;
            end else begin
                pready  = 1'b0;
                prdata  = $urandom;
                pslverr = 1'($urandom);
            end
            slv_n++;
        end else begin
            slv_n   = 0;
            pready  = 1'($urandom);
            prdata  = $urandom;
            pslverr = 1'($urandom);
        end
    end

    // Monitor: checks SETUP contents, ACCESS stability and the response against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            acc_seen = 0;
        end else begin
            if (psel && !penable) begin
                check("setup_has_txn", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_e = sb[0];
                    check("setup_cycle", 64'(cyc), 64'(mon_e.acc_cyc + 1));
                    check("setup_paddr", 64'(paddr), 64'(mon_e.addr));
                    check("setup_pwrite", 64'(pwrite), 64'(mon_e.write));
                    check("setup_pwdata", 64'(pwdata), mon_e.write ? 64'(mon_e.wdata) : 64'd0);
                    check("setup_pstrb", 64'(pstrb), mon_e.write ? 64'(mon_e.strb) : 64'd0);
                end
            end
            if (psel && penable) begin
                acc_seen++;
                if (sb.size() != 0)
                    check("access_hold", {pwrite, paddr, pwdata, pstrb},
                          {mon_e.write, mon_e.addr, mon_e.write ? mon_e.wdata : 32'd0,
                           mon_e.write ? mon_e.strb : 4'd0});
            end
            if (rsp_valid) begin
                check("rsp_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("rsp_cycle", 64'(cyc), 64'(mon_e.acc_cyc + 2 + mon_e.acc_cycles));
                    check("access_cycles", 64'(acc_seen), 64'(mon_e.acc_cycles));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                    check("rsp_fail", 64'(rsp_fail), 64'(mon_e.fail));
                    check("rsp_timeout", 64'(rsp_timeout), 64'(mon_e.tmo));
                    check("err_cnt", 64'(err_cnt), 64'(mon_e.err));
                    check("idle_bus", {psel, penable, pwrite, paddr, pwdata, pstrb, cmd_ready},
                          {3'b000, 12'd0, 32'd0, 4'd0, 1'b1});
                end
                acc_seen = 0;
            end
        end
    end

    function automatic txn_t mk(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                                input logic [DATA_W-1:0] ex, input logic [DATA_W-1:0] mk_mask,
                                input bit xe, input int wt, input logic [DATA_W-1:0] rd, input bit se);
        txn_t t;
        t.write = w;    t.addr = a;     t.wdata = wd;  t.strb = 4'hF;
        t.exp = ex;     t.mask = mk_mask; t.experr = xe; t.waits = wt;
        t.rdata = rd;   t.slverr = se;  t.clr = 1'b0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.write  = 1'($urandom);
        t.addr   = ADDR_W'($urandom);
        t.wdata  = $urandom;
        t.strb   = STRB_W'($urandom);
        t.exp    = $urandom;
        case ($urandom_range(0, 2))
            0:       t.mask = '1;
            1:       t.mask = $urandom;
            default: t.mask = '0;
        endcase
        case ($urandom_range(0, 2))
            0:       t.rdata = t.exp;
            1:       t.rdata = t.exp ^ (32'h1 << $urandom_range(0, 31));
            default: t.rdata = $urandom;
        endcase
        t.slverr = 1'($urandom);
        t.experr = ($urandom_range(0, 3) == 0) ? !t.slverr : t.slverr;
        case ($urandom_range(0, 15))
            0:       t.waits = TIMEOUT - 1;
            1:       t.waits = TIMEOUT;
            2:       t.waits = STUCK;
            3:       t.waits = 7;
            default: t.waits = $urandom_range(0, 3);
        endcase
        t.clr = ($urandom_range(0, 9) == 0);
        return t;
    endfunction

    // Reference model: outcome of one command from the slave's behaviour and the checking rules.
    function automatic exp_t predict(input txn_t t, input int acc_cyc, input int cnt_before);
        exp_t e;
        int   miss_bits;
        e.acc_cyc    = acc_cyc;
        e.write      = t.write;
        e.addr       = t.addr;
        e.wdata      = t.wdata;
        e.strb       = t.strb;
        e.tmo        = (t.waits >= TIMEOUT);
        e.acc_cycles = e.tmo ? TIMEOUT : t.waits + 1;
        miss_bits = 0;
        for (int i = 0; i < DATA_W; i++)
            if (!t.write && t.mask[i] && (t.rdata[i] != t.exp[i])) miss_bits++;
        e.fail  = e.tmo || (t.slverr != t.experr) || (miss_bits > 0);
        e.rdata = (t.write || e.tmo) ? '0 : t.rdata;
        if (t.clr)                           e.err = e.fail ? 1 : 0;
        else if (e.fail && cnt_before < ERR_MAX) e.err = cnt_before + 1;
        else                                 e.err = cnt_before;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge just before the accepting edge.
    task automatic present(input txn_t t, output bit ok);
        exp_t e;
        int   n;
        cmd_valid  = 1'b1;
        cmd_write  = t.write;
        cmd_addr   = t.addr;
        cmd_wdata  = t.wdata;
        cmd_strb   = t.strb;
        cmd_exp    = t.exp;
        cmd_mask   = t.mask;
        cmd_experr = t.experr;
        err_clr    = t.clr;
        slv_waits  = t.waits;
        slv_rdata  = t.rdata;
        slv_slverr = t.slverr;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = cmd_ready;
        if (!ok) begin
            check("cmd_accept", 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b0;
        end else begin
            e = predict(t, cyc, mcnt);
            mcnt = e.err;
            sb.push_back(e);
        end
    endtask

    // Runs the whole command, scrambling cmd_* while busy; returns at the response negedge.
    task automatic issue(input txn_t t);
        bit ok;
        int busy;
        present(t, ok);
        if (ok) begin
            busy = 1 + ((t.waits >= TIMEOUT) ? TIMEOUT : t.waits + 1);
            for (int i = 0; i < busy; i++) begin
                @(negedge clk);
                cmd_valid  = 1'($urandom);
                cmd_write  = 1'($urandom);
                cmd_addr   = ADDR_W'($urandom);
                cmd_wdata  = $urandom;
                cmd_strb   = STRB_W'($urandom);
                cmd_exp    = $urandom;
                cmd_mask   = $urandom;
                cmd_experr = 1'($urandom);
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        txn_t t;
        bit   ok;
        total = 0; bad = 0; cyc = 0; mcnt = 0; acc_seen = 0;
        slv_n = 0; slv_waits = 0; slv_rdata = '0; slv_slverr = 1'b0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        rst_n = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        cmd_exp = '0; cmd_mask = '0; cmd_experr = 1'b0; err_clr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset_apb", {psel, penable, pwrite, paddr, pwdata, pstrb}, 64'd0);
        check("reset_rsp", {rsp_valid, rsp_fail, rsp_timeout, rsp_rdata}, 64'd0);
        check("reset_err_cnt", 64'(err_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);

        // Directed: basic write, masked read compare, slave error with wait states, timeout edge.
        issue(mk(1'b1, 12'h000, 32'h0000_0001, '0, '0, 1'b0, 0, '0, 1'b0));
        idle(1);
        issue(mk(1'b0, 12'h004, '0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 0, 32'h1234_5679, 1'b0));
        idle(1);
        issue(mk(1'b0, 12'h004, '0, 32'h1234_5678, 32'hFFFF_FFFE, 1'b0, 0, 32'h1234_5679, 1'b0));
        idle(1);
        issue(mk(1'b1, 12'hFFC, 32'hA5A5_5A5A, '0, '0, 1'b1, 3, '0, 1'b1));
        idle(1);
        issue(mk(1'b1, 12'hFFC, 32'hA5A5_5A5A, '0, '0, 1'b0, 3, '0, 1'b1));
        idle(1);
        issue(mk(1'b0, 12'h010, '0, 32'hCAFE_0000, 32'hFFFF_FFFF, 1'b0, TIMEOUT - 1, 32'hCAFE_0000, 1'b0));
        issue(mk(1'b0, 12'h014, '0, 32'h0, 32'h0, 1'b0, STUCK, 32'h0, 1'b0));
        issue(mk(1'b1, 12'h018, 32'h1, '0, '0, 1'b0, 0, '0, 1'b0));
        idle(2);

        // Random traffic with back-to-back and gapped commands.
        for (int i = 0; i < 200; i++) begin
            issue(rand_txn());
            idle($urandom_range(0, 2));
        end
        idle(2);

        // Saturation: failing reads past the counter's all-ones value, then clear-with-fail.
        for (int i = 0; i < ERR_MAX + 4; i++)
            issue(mk(1'b0, 12'h020, '0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0, 0, 32'hF0F0_F0F0, 1'b0));
        t = mk(1'b0, 12'h024, '0, 32'h1, 32'h1, 1'b0, 0, 32'h0, 1'b0);
        t.clr = 1'b1;
        issue(t);
        idle(2);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        mcnt = 0;
        check("err_clr_alone", 64'(err_cnt), 64'd0);
        idle(1);

        // Reset in the middle of ACCESS.
        issue(mk(1'b1, 12'h030, 32'h5, '0, '0, 1'b1, 0, '0, 1'b0));
        idle(1);
        present(mk(1'b0, 12'h034, '0, '0, '0, 1'b0, STUCK, '0, 1'b0), ok);
        repeat (4) @(negedge clk);
        cmd_valid = 1'b0;
        check("pre_reset_penable", 64'(penable), 64'd1);
        #2;
        rst_n = 1'b1;
        #1;
        check("mid_reset_psel_penable", {psel, penable}, 64'd0);
        check("mid_reset_cmd_ready", 64'(cmd_ready), 64'd1);
        check("mid_reset_err_cnt", 64'(err_cnt), 64'd0);
        check("mid_reset_rsp_valid", 64'(rsp_valid), 64'd0);
        sb.delete();
        mcnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        idle(10);
        issue(mk(1'b0, 12'h038, '0, 32'h77, 32'hFF, 1'b0, 1, 32'h77, 1'b0));
        idle(5);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
